integral_rect_reader: RTL and testbench

//  Reads a finished 20x20 integral image (written by the classifier stage) through a 1-cycle-latency

---
 rtl/integral_rect_reader.sv | 146 ++++++++++++++
 tb/tb_integral_rect_reader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/integral_rect_reader.sv
// Haar rectangle-sum reader: fetches up to four integral-image corners over a
// 1-cycle-latency read port and returns D - B - C + A with a fixed 6-cycle latency.
module integral_rect_reader #(
  parameter int IMG_W   = 20,
  parameter int IMG_H   = 20,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int COORD_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               img_ready,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  input  logic [COORD_W-1:0] req_w,
  input  logic [COORD_W-1:0] req_h,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_sum,
  output logic               res_err,
  output logic [15:0]        query_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_D   = 3'd1;
  localparam logic [2:0] S_RD_B   = 3'd2;
  localparam logic [2:0] S_RD_C   = 3'd3;
  localparam logic [2:0] S_RD_A   = 3'd4;
  localparam logic [2:0] S_CAP    = 3'd5;
  localparam logic [2:0] S_RESULT = 3'd6;

  localparam logic [COORD_W:0] ONE   = (COORD_W+1)'(1);
  localparam logic [COORD_W:0] LIM_X = (COORD_W+1)'(IMG_W);
  localparam logic [COORD_W:0] LIM_Y = (COORD_W+1)'(IMG_H);

  logic [2:0]         state;
  logic [COORD_W-1:0] x_q, y_q, w_q, h_q;
  logic               stale;
  logic               term_en;
  logic               term_sub;
  logic [DATA_W-1:0]  acc;

  logic [COORD_W:0]   x_end, y_end, col_r, row_b, col_l, row_t;
  logic               req_ok, need_top, need_left;

  // Extent sums use one extra bit so X+W and Y+H can never wrap.
  assign x_end     = {1'b0, x_q} + {1'b0, w_q};
  assign y_end     = {1'b0, y_q} + {1'b0, h_q};
  assign col_r     = x_end - ONE;
  assign row_b     = y_end - ONE;
  assign col_l     = {1'b0, x_q} - ONE;
  assign row_t     = {1'b0, y_q} - ONE;
  assign need_top  = (y_q != '0);
  assign need_left = (x_q != '0);
  assign req_ok    = (w_q != '0) && (h_q != '0) && (x_end <= LIM_X) && (y_end <= LIM_Y);

  function automatic logic [ADDR_W-1:0] addr_of(input logic [COORD_W:0] r,
                                                input logic [COORD_W:0] c);
    return ADDR_W'(r) * ADDR_W'(IMG_W) + ADDR_W'(c);
  endfunction

  assign req_ready = !reset && (state == S_IDLE) && img_ready;
  assign res_valid = !reset && (state == S_RESULT);
  assign res_sum   = res_valid ? acc : '0;
  assign res_err   = res_valid && (!req_ok || stale);

  // Corner reads: each RD state owns one slot, skipped corners leave the port idle.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (!reset && req_ok) begin
      case (state)
        S_RD_D: begin
          rd_en   = 1'b1;
          rd_addr = addr_of(row_b, col_r);
        end
        S_RD_B: if (need_top) begin
          rd_en   = 1'b1;
          rd_addr = addr_of(row_t, col_r);
        end
        S_RD_C: if (need_left) begin
          rd_en   = 1'b1;
          rd_addr = addr_of(row_b, col_l);
        end
        S_RD_A: if (need_top && need_left) begin
          rd_en   = 1'b1;
          rd_addr = addr_of(row_t, col_l);
        end
        default: ;
      endcase
    end
  end

  // term_sub marks the B and C words, which arrive during RD_C and RD_A.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      stale     <= 1'b0;
      term_en   <= 1'b0;
      term_sub  <= 1'b0;
      acc       <= '0;
      query_cnt <= '0;
    end else begin
      term_en  <= rd_en;
      term_sub <= (state == S_RD_B) || (state == S_RD_C);
      if (term_en)
        acc <= term_sub ? acc - rd_data : acc + rd_data;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            x_q   <= req_x;
            y_q   <= req_y;
            w_q   <= req_w;
            h_q   <= req_h;
            acc   <= '0;
            stale <= 1'b0;
            state <= S_RD_D;
          end
        end
        S_RD_D, S_RD_B, S_RD_C, S_RD_A, S_CAP: begin
          if (!img_ready)
            stale <= 1'b1;
          state <= state + 3'd1;
        end
        S_RESULT: begin
          if (res_ready) begin
            state <= S_IDLE;
            if (query_cnt != 16'hFFFF)
              query_cnt <= query_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_integral_rect_reader.sv
// Randomized self-checking bench for integral_rect_reader: a pixel-level model
// of the image supplies expected sums, corner addresses, error flags and latency.
module tb_integral_rect_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        img_ready = 1'b1;
  logic        req_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [4:0]  req_x = '0, req_y = '0, req_w = '0, req_h = '0;
  logic        req_ready, rd_en, res_valid, res_err;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic [31:0] res_sum;
  logic [15:0] query_cnt;

  int tests_run = 0;
  int fails = 0;
  int exp_cnt = 0;

  logic [31:0] pix[400];
  logic [31:0] ii[400];
  int addr_q[$];
  int exp_q[$];

  always #5 clk = ~clk;

  integral_rect_reader dut (
    .clk(clk), .reset(reset), .img_ready(img_ready),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_err(res_err), .query_cnt(query_cnt)
  );

  // Integral store: garbage on cycles without a read so stray captures show up.
  always @(posedge clk) begin
    if (rd_en && rd_addr < 9'd400) rd_data <= ii[rd_addr];
    else                           rd_data <= $urandom;
  end

  always @(negedge clk) begin
    if (rd_en) addr_q.push_back(int'(rd_addr));
  end

  task automatic load_image(input bit ones);
    for (int i = 0; i < 400; i++) pix[i] = ones ? 32'd1 : 32'($urandom_range(0, 65535));
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 20; c++) begin
        ii[r*20+c] = pix[r*20+c];
        if (r > 0) ii[r*20+c] += ii[(r-1)*20+c];
        if (c > 0) ii[r*20+c] += ii[r*20+c-1];
        if (r > 0 && c > 0) ii[r*20+c] -= ii[(r-1)*20+c-1];
      end
  endtask

  function automatic bit rect_ok(input int x, input int y, input int w, input int h);
    return (w >= 1) && (h >= 1) && (x + w <= 20) && (y + h <= 20);
  endfunction

  function automatic logic [31:0] rect_sum(input int x, input int y, input int w, input int h);
    logic [31:0] s = 0;
    if (!rect_ok(x, y, w, h)) return 32'd0;
    for (int r = y; r < y + h; r++)
      for (int c = x; c < x + w; c++) s += pix[r*20+c];
    return s;
  endfunction

  task automatic build_expected(input int x, input int y, input int w, input int h);
    exp_q.delete();
    if (rect_ok(x, y, w, h)) begin
      exp_q.push_back((y+h-1)*20 + x+w-1);
      if (y > 0) exp_q.push_back((y-1)*20 + x+w-1);
      if (x > 0) exp_q.push_back((y+h-1)*20 + x-1);
      if (x > 0 && y > 0) exp_q.push_back((y-1)*20 + x-1);
    end
  endtask

  function automatic bit addrs_match();
    if (addr_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (addr_q[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Caller is at a negedge; returns at the negedge where res_valid is seen (res_ready low).
  task automatic issue(input int x, input int y, input int w, input int h, input int drop_at,
                       output int lat, output logic [31:0] sum, output logic err);
    int n = 0;
    req_x = 5'(x); req_y = 5'(y); req_w = 5'(w); req_h = 5'(h);
    req_valid = 1'b1;
    addr_q.delete();
    #1;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    lat = 0; sum = '0; err = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      img_ready = (c != drop_at);
      if (res_valid) begin
        lat = c; sum = res_sum; err = res_err;
        break;
      end
    end
    img_ready = 1'b1;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk);
    if (exp_cnt < 65535) exp_cnt++;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (req_ready !== 1'b0 || rd_en !== 1'b0 || res_valid !== 1'b0 || query_cnt !== 16'd0) begin
        fails++;
        $display("[TB] FAIL reset_state: got ready=%b rd_en=%b valid=%b cnt=%0d required 0/0/0/0",
                 req_ready, rd_en, res_valid, query_cnt);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_after_reset: got %b required 1", req_ready);
    end
  endtask

  task automatic test_not_ready();
    img_ready = 1'b0;
    req_x = 5'd0; req_y = 5'd0; req_w = 5'd1; req_h = 5'd1;
    req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests_run++;
      if (req_ready !== 1'b0 || rd_en !== 1'b0) begin
        fails++;
        $display("[TB] FAIL not_ready_idle: got ready=%b rd_en=%b required 0/0", req_ready, rd_en);
      end
    end
    req_valid = 1'b0;
    img_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL not_ready_no_query: got valid=%b ready=%b required 0/1", res_valid, req_ready);
    end
  endtask

  task automatic test_directed();
    int tx[7] = '{0, 3, 0, 0, 18, 2, 19};
    int ty[7] = '{0, 4, 0, 5, 0, 2, 19};
    int tw[7] = '{1, 5, 20, 4, 5, 0, 1};
    int th[7] = '{1, 2, 20, 3, 1, 3, 1};
    int lat;
    logic [31:0] sum, esum;
    logic err, eerr;
    for (int i = 0; i < 7; i++) begin
      build_expected(tx[i], ty[i], tw[i], th[i]);
      esum = rect_sum(tx[i], ty[i], tw[i], th[i]);
      eerr = !rect_ok(tx[i], ty[i], tw[i], th[i]);
      issue(tx[i], ty[i], tw[i], th[i], 0, lat, sum, err);
      tests_run++;
      if (lat != 6) begin
        fails++; $display("[TB] FAIL directed%0d_latency: got %0d required 6", i, lat);
      end
      tests_run++;
      if (sum !== esum || err !== eerr) begin
        fails++;
        $display("[TB] FAIL directed%0d_result: got sum=%0d err=%b required sum=%0d err=%b", i, sum, err, esum, eerr);
      end
      tests_run++;
      if (!addrs_match()) begin
        fails++;
        $display("[TB] FAIL directed%0d_reads: got %p required %p", i, addr_q, exp_q);
      end
      release_result();
    end
  endtask

  task automatic test_stale();
    int lat;
    logic [31:0] sum;
    logic err;
    issue(3, 4, 5, 2, 2, lat, sum, err);
    tests_run++;
    if (lat != 6 || sum !== 32'd10 || err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL stale_in_rd_b: got lat=%0d sum=%0d err=%b required 6/10/1", lat, sum, err);
    end
    release_result();
  endtask

  task automatic test_hold();
    int lat;
    logic [31:0] sum;
    logic err;
    int cnt_before;
    issue(3, 4, 5, 2, 0, lat, sum, err);
    cnt_before = exp_cnt;
    tests_run++;
    if (lat != 6 || sum !== 32'd10) begin
      fails++; $display("[TB] FAIL hold_first: got lat=%0d sum=%0d required 6/10", lat, sum);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (res_valid !== 1'b1 || res_sum !== 32'd10 || res_err !== 1'b0 || req_ready !== 1'b0 ||
          query_cnt !== 16'(cnt_before)) begin
        fails++;
        $display("[TB] FAIL hold_stable: got valid=%b sum=%0d err=%b ready=%b cnt=%0d required 1/10/0/0/%0d",
                 res_valid, res_sum, res_err, req_ready, query_cnt, cnt_before);
      end
    end
    release_result();
    tests_run++;
    if (query_cnt !== 16'(cnt_before + 1) || res_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL hold_release: got cnt=%0d valid=%b required %0d/0", query_cnt, res_valid, cnt_before + 1);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] sum;
    logic err;
    issue(0, 0, 2, 2, 0, lat, sum, err);
    release_result();
    tests_run++;
    if (req_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL b2b_ready: got %b required 1", req_ready);
    end
    issue(1, 1, 3, 3, 0, lat, sum, err);
    tests_run++;
    if (lat != 6 || sum !== 32'd9 || err !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_second: got lat=%0d sum=%0d err=%b required 6/9/0", lat, sum, err);
    end
    release_result();
  endtask

  task automatic test_random();
    int x, y, w, h, drop, lat;
    logic [31:0] sum, esum;
    logic err, eerr;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        x = $urandom_range(0, 31); y = $urandom_range(0, 31);
        w = $urandom_range(0, 31); h = $urandom_range(0, 31);
      end else begin
        x = $urandom_range(0, 19); y = $urandom_range(0, 19);
        w = $urandom_range(0, 21 - x); h = $urandom_range(0, 21 - y);
      end
      drop = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5) : 0;
      build_expected(x, y, w, h);
      esum = rect_sum(x, y, w, h);
      eerr = !rect_ok(x, y, w, h) || (drop != 0);
      issue(x, y, w, h, drop, lat, sum, err);
      tests_run++;
      if (lat != 6 || sum !== esum || err !== eerr) begin
        fails++;
        $display("[TB] FAIL random%0d (%0d,%0d,%0d,%0d drop%0d): got lat=%0d sum=%0d err=%b required 6/%0d/%b",
                 i, x, y, w, h, drop, lat, sum, err, esum, eerr);
      end
      tests_run++;
      if (!addrs_match()) begin
        fails++;
        $display("[TB] FAIL random%0d_reads: got %p required %p", i, addr_q, exp_q);
      end
      release_result();
    end
    tests_run++;
    if (query_cnt !== 16'(exp_cnt)) begin
      fails++; $display("[TB] FAIL query_count: got %0d required %0d", query_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_midquery();
    bit seen_valid = 1'b0;
    req_x = 5'd3; req_y = 5'd4; req_w = 5'd5; req_h = 5'd2;
    req_valid = 1'b1;
    #1;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b0 || rd_en !== 1'b0 || rd_addr !== 9'd0 || res_valid !== 1'b0 ||
        res_sum !== 32'd0 || res_err !== 1'b0 || query_cnt !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_midquery: got ready=%b rd_en=%b addr=%0d valid=%b sum=%0d err=%b cnt=%0d required all 0",
               req_ready, rd_en, rd_addr, res_valid, res_sum, res_err, query_cnt);
    end
    reset = 1'b0;
    exp_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) seen_valid = 1'b1;
    end
    tests_run++;
    if (seen_valid || req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_aborts_query: got valid_seen=%b ready=%b required 0/1", seen_valid, req_ready);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    load_image(1'b1);
    test_reset();
    test_not_ready();
    test_directed();
    test_stale();
    test_hold();
    test_back_to_back();
    load_image(1'b0);
    test_random();
    test_reset_midquery();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
